// File: rtl/bus_bram_slave_pkg.sv
// Shared bus parameters and slave state encoding for the bit-serial system bus.
package bus_bram_slave_pkg;

  localparam int BUS_ADDR_LEN        = 12;
  localparam int BUS_DATA_LEN        = 8;
  localparam int BUS_BURST_LEN       = 12;
  localparam int BUS_SPLIT_THRESHOLD = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_BURST  = 3'd2;
  localparam logic [2:0] ST_WDATA  = 3'd3;
  localparam logic [2:0] ST_RWAIT  = 3'd4;
  localparam logic [2:0] ST_RFETCH = 3'd5;
  localparam logic [2:0] ST_RDATA  = 3'd6;

endpackage

// File: rtl/bus_bram_slave_bram_sp.sv
// Single-port synchronous RAM; read returns the pre-write contents.
module bram_sp
  import bus_bram_slave_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_LEN,
  parameter int DATA_W = BUS_DATA_LEN
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_bram_slave.sv
// Bit-serial bus slave wrapping a block RAM: serial address/burst/data in,
// serial read data out under valid/ready, with optional split on long read waits.
module bus_bram_slave
  import bus_bram_slave_pkg::*;
#(
  parameter int ADDR_LEN        = BUS_ADDR_LEN,
  parameter int DATA_LEN        = BUS_DATA_LEN,
  parameter int BURST_LEN       = BUS_BURST_LEN,
  parameter int SPLIT_THRESHOLD = BUS_SPLIT_THRESHOLD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] slave_delay,
  input  logic       read_en,
  input  logic       write_en,
  input  logic       master_valid,
  input  logic       master_ready,
  input  logic       rx_address,
  input  logic       rx_burst,
  input  logic       rx_data,
  output logic       tx_data,
  output logic       slave_valid,
  output logic       slave_ready,
  output logic       split_en
);

  localparam int         CNT_W     = $clog2(ADDR_LEN + BURST_LEN + DATA_LEN);
  localparam logic [5:0] SPLIT_LVL = 6'(SPLIT_THRESHOLD);

  logic [2:0]           state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [BURST_LEN-1:0] beats, beats_nxt;
  logic [5:0]           wait_cnt, wait_cnt_nxt;
  logic                 is_write, is_write_nxt;
  logic [ADDR_LEN-1:0]  addr, addr_nxt, ram_addr;
  logic [BURST_LEN-1:0] burst, burst_nxt, burst_val;
  logic [DATA_LEN-1:0]  wdata, wdata_nxt, tx_shift, tx_shift_nxt;
  logic [DATA_LEN-1:0]  ram_wdata, rdata;
  logic                 ram_we, aborted;

  assign burst_val = {rx_burst, burst[BURST_LEN-1:1]};
  assign ram_wdata = {rx_data, wdata[DATA_LEN-1:1]};
  assign aborted   = (state != ST_IDLE) && (is_write ? !write_en : !read_en);

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    beats_nxt    = beats;
    wait_cnt_nxt = wait_cnt;
    is_write_nxt = is_write;
    addr_nxt     = addr;
    burst_nxt    = burst;
    wdata_nxt    = wdata;
    tx_shift_nxt = tx_shift;
    ram_we       = 1'b0;
    if (aborted) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (master_valid && (read_en ^ write_en)) begin
            addr_nxt     = {rx_address, addr[ADDR_LEN-1:1]};
            is_write_nxt = write_en;
            bit_cnt_nxt  = CNT_W'(1);
            state_nxt    = ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (master_valid) begin
            addr_nxt = {rx_address, addr[ADDR_LEN-1:1]};
            if (bit_cnt == CNT_W'(ADDR_LEN - 1)) begin
              bit_cnt_nxt = '0;
              state_nxt   = ST_BURST;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_BURST: begin
          if (master_valid) begin
            burst_nxt = burst_val;
            if (bit_cnt == CNT_W'(BURST_LEN - 1)) begin
              beats_nxt    = (burst_val == '0) ? BURST_LEN'(1) : burst_val;
              bit_cnt_nxt  = '0;
              wait_cnt_nxt = '0;
              if (is_write)                state_nxt = ST_WDATA;
              else if (slave_delay == 6'd0) state_nxt = ST_RFETCH;
              else                          state_nxt = ST_RWAIT;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_WDATA: begin
          if (master_valid) begin
            wdata_nxt = ram_wdata;
            if (bit_cnt == CNT_W'(DATA_LEN - 1)) begin
              ram_we      = 1'b1;
              addr_nxt    = addr + ADDR_LEN'(1);
              beats_nxt   = beats - BURST_LEN'(1);
              bit_cnt_nxt = '0;
              if (beats == BURST_LEN'(1)) state_nxt = ST_IDLE;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_RWAIT: begin
          if (wait_cnt + 6'd1 >= slave_delay) state_nxt = ST_RFETCH;
          else                                wait_cnt_nxt = wait_cnt + 6'd1;
        end
        ST_RFETCH: begin
          tx_shift_nxt = rdata;
          bit_cnt_nxt  = '0;
          state_nxt    = ST_RDATA;
        end
        ST_RDATA: begin
          if (master_ready) begin
            tx_shift_nxt = tx_shift >> 1;
            if (bit_cnt == CNT_W'(DATA_LEN - 1)) begin
              addr_nxt     = addr + ADDR_LEN'(1);
              beats_nxt    = beats - BURST_LEN'(1);
              bit_cnt_nxt  = '0;
              wait_cnt_nxt = '0;
              if (beats == BURST_LEN'(1))   state_nxt = ST_IDLE;
              else if (slave_delay == 6'd0) state_nxt = ST_RFETCH;
              else                          state_nxt = ST_RWAIT;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Reads look ahead to the next address so RFETCH sees the post-increment word.
  assign ram_addr = ram_we ? addr : addr_nxt;

  bram_sp #(
    .ADDR_W(ADDR_LEN),
    .DATA_W(DATA_LEN)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      beats    <= '0;
      wait_cnt <= '0;
      is_write <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      beats    <= beats_nxt;
      wait_cnt <= wait_cnt_nxt;
      is_write <= is_write_nxt;
    end
  end

  always_ff @(posedge clk) begin
    addr     <= addr_nxt;
    burst    <= burst_nxt;
    wdata    <= wdata_nxt;
    tx_shift <= tx_shift_nxt;
  end

  assign slave_ready = (state == ST_IDLE);
  assign slave_valid = (state == ST_RDATA);
  assign tx_data     = slave_valid & tx_shift[0];
  assign split_en    = (state == ST_RWAIT) && (slave_delay >= SPLIT_LVL);

endmodule

// File: tb/tb_bus_bram_slave.sv
// Randomized bench for bus_bram_slave against a word-level memory model.
module tb_bus_bram_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] slave_delay;
  logic       read_en, write_en, master_valid, master_ready;
  logic       rx_address, rx_burst, rx_data;
  logic       tx_data, slave_valid, slave_ready, split_en;

  int   n_vec = 0;
  int   n_err = 0;
  bit   use_gaps = 1'b0;
  logic [7:0] mdl [4096];
  bit         known [4096];
  int   rec_addr[$];
  int   rec_beats[$];

  bus_bram_slave dut (
    .clk         (clk),
    .rst         (rst),
    .slave_delay (slave_delay),
    .read_en     (read_en),
    .write_en    (write_en),
    .master_valid(master_valid),
    .master_ready(master_ready),
    .rx_address  (rx_address),
    .rx_burst    (rx_burst),
    .rx_data     (rx_data),
    .tx_data     (tx_data),
    .slave_valid (slave_valid),
    .slave_ready (slave_ready),
    .split_en    (split_en)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    if (use_gaps)
      while ($urandom_range(3) == 0) begin
        master_valid = 1'b0;
        step();
      end
  endtask

  task automatic send_header(input bit wr, input logic [11:0] a, input logic [11:0] b);
    logic [23:0] hdr;
    hdr      = {b, a};
    write_en = wr;
    read_en  = !wr;
    for (int i = 0; i < 24; i++) begin
      gap();
      master_valid = 1'b1;
      rx_address   = hdr[i];
      rx_burst     = hdr[i];
      step();
    end
    master_valid = 1'b0;
  endtask

  task automatic do_write(input int a, input int burst, input logic [31:0] words);
    int beats;
    beats = (burst == 0) ? 1 : burst;
    chk("wr_idle_ready", 32'(slave_ready), 32'd1);
    send_header(1'b1, 12'(a), 12'(burst));
    for (int k = 0; k < beats; k++) begin
      for (int i = 0; i < 8; i++) begin
        gap();
        master_valid = 1'b1;
        rx_data      = words[8*k+i];
        step();
      end
      master_valid = 1'b0;
      mdl[(a + k) % 4096]   = words[8*k +: 8];
      known[(a + k) % 4096] = 1'b1;
      chk("wr_ready_after_beat", 32'(slave_ready), 32'(k == beats - 1));
    end
    write_en = 1'b0;
  endtask

  // mode 0: master_ready always high, 1: toggles 1,0,1,0..., 2: random
  task automatic do_read(input int a, input int burst, input int delay, input int mode);
    int beats, waited, b, cyc, loc;
    logic [7:0] got, exp;
    bit tog;
    beats       = (burst == 0) ? 1 : burst;
    slave_delay = 6'(delay);
    chk("rd_idle_ready", 32'(slave_ready), 32'd1);
    send_header(1'b0, 12'(a), 12'(burst));
    for (int k = 0; k < beats; k++) begin
      waited = 0;
      while (!slave_valid && waited < 300) begin
        chk("rd_split_wait", 32'(split_en), 32'(waited < delay && delay >= 8));
        step();
        waited++;
      end
      chk("rd_latency", 32'(waited), 32'(delay + 1));
      if (!slave_valid) begin
        read_en = 1'b0;
        step();
        return;
      end
      loc = (a + k) % 4096;
      exp = mdl[loc];
      got = '0;
      b   = 0;
      cyc = 0;
      tog = 1'b1;
      while (b < 8 && cyc < 200) begin
        chk("rd_valid", 32'(slave_valid), 32'd1);
        chk("rd_split_low", 32'(split_en), 32'd0);
        if (known[loc]) chk("rd_bit", 32'(tx_data), 32'(exp[b]));
        master_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(1));
        tog = !tog;
        if (master_ready) begin
          got[b] = tx_data;
          b++;
        end
        step();
        cyc++;
      end
      master_ready = 1'b0;
      chk("rd_bits_accepted", 32'(b), 32'd8);
      if (known[loc]) chk("rd_word", 32'(got), 32'(exp));
    end
    chk("rd_end_valid", 32'(slave_valid), 32'd0);
    chk("rd_end_ready", 32'(slave_ready), 32'd1);
    read_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(slave_ready), 32'd1);
    chk({tag, "_valid"}, 32'(slave_valid), 32'd0);
    chk({tag, "_tx"},    32'(tx_data),     32'd0);
    chk({tag, "_split"}, 32'(split_en),    32'd0);
  endtask

  initial begin
    int a, bu, idx, cnt;
    logic [7:0] abort_word;
    rst = 1'b0;
    slave_delay  = '0;
    read_en      = 1'b0;
    write_en     = 1'b0;
    master_valid = 1'b0;
    master_ready = 1'b0;
    rx_address   = 1'b0;
    rx_burst     = 1'b0;
    rx_data      = 1'b0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b1;
    step();

    // single write then read, no split
    do_write(12'h005, 1, 32'h0000_00A5);
    do_read(12'h005, 1, 0, 0);

    // burst write across the top of memory
    do_write(12'hFFE, 3, 32'h0033_2211);
    do_read(12'hFFE, 3, 0, 0);
    do_read(12'h000, 1, 0, 0);

    // long delay raises split
    do_read(12'h005, 1, 10, 0);
    do_read(12'hFFF, 2, 9, 0);

    // backpressure
    do_read(12'h005, 1, 0, 1);
    do_read(12'hFFE, 2, 3, 1);

    // burst count 0 behaves as one beat
    do_write(12'h100, 0, 32'h0000_005A);
    do_read(12'h100, 0, 2, 0);

    // abort a write after 4 data bits
    abort_word = 8'h3C;
    send_header(1'b1, 12'h005, 12'd1);
    for (int i = 0; i < 4; i++) begin
      master_valid = 1'b1;
      rx_data      = abort_word[i];
      step();
    end
    master_valid = 1'b0;
    write_en     = 1'b0;
    step();
    chk("abort_ready", 32'(slave_ready), 32'd1);
    do_read(12'h005, 1, 0, 0);

    // both enables high in IDLE are ignored
    read_en  = 1'b1;
    write_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      master_valid = 1'b1;
      rx_address   = 1'($urandom_range(1));
      rx_burst     = 1'($urandom_range(1));
      step();
      chk("both_en_idle", 32'(slave_ready), 32'd1);
    end
    read_en      = 1'b0;
    write_en     = 1'b0;
    master_valid = 1'b0;
    step();
    do_read(12'hFFE, 1, 0, 0);

    // reset during a long read wait
    slave_delay = 6'd12;
    send_header(1'b0, 12'h005, 12'd1);
    step();
    step();
    chk("rst_wait_split", 32'(split_en), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_wait");
    read_en = 1'b0;
    step();
    rst = 1'b1;
    step();

    // reset while shifting out read data
    slave_delay = 6'd0;
    send_header(1'b0, 12'h005, 12'd1);
    cnt = 0;
    while (!slave_valid && cnt < 20) begin
      step();
      cnt++;
    end
    chk("rst_rd_reach", 32'(slave_valid), 32'd1);
    master_ready = 1'b1;
    step();
    step();
    rst          = 1'b0;
    master_ready = 1'b0;
    #1;
    check_reset_outputs("rst_rdata");
    read_en = 1'b0;
    step();
    rst = 1'b1;
    step();
    do_read(12'h005, 1, 0, 0);

    // randomized traffic with valid gaps and random backpressure
    use_gaps = 1'b1;
    repeat (25) begin
      a  = $urandom_range(4095);
      bu = $urandom_range(4);
      do_write(a, bu, $urandom);
      rec_addr.push_back(a);
      rec_beats.push_back((bu == 0) ? 1 : bu);
      idx = $urandom_range(rec_addr.size() - 1);
      do_read(rec_addr[idx], $urandom_range(rec_beats[idx]), $urandom_range(12), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_bram_slave.md
# bus_bram_slave

Bit-serial bus responder: a 4K×8 block RAM reachable as one slave port of the system bus interconnect (the `sN_*` side). It receives serial address, burst count and write data from the interconnect, and performs single or burst reads and writes with address auto-increment. Read data returns serially under a valid/ready handshake. A programmable read delay optionally raises split so the arbiter can release the bus.

## Interface
- `ADDR_LEN`, default 12: address bits; memory depth is 2^ADDR_LEN.
- `DATA_LEN`, default 8: word width.
- `BURST_LEN`, default 12: burst-count bits.
- `SPLIT_THRESHOLD`, default 8: `slave_delay` values ≥ this assert split.

Ports:
- `clk`  in  1  bus clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `slave_delay`  in  6  wait cycles inserted before each read beat.
- `read_en`  in  1  read transaction active.
- `write_en`  in  1  write transaction active.
- `master_valid`  in  1  qualifies `rx_address` / `rx_burst` / `rx_data` bits.
- `master_ready`  in  1  master accepts the current `tx_data` bit.
- `rx_address`  in  1  serial address, LSB first.
- `rx_burst`  in  1  serial burst count, LSB first.
- `rx_data`  in  1  serial write data, LSB first.
- `tx_data`  out  1  serial read data, LSB first.
- `slave_valid`  out  1  `tx_data` holds a valid bit.
- `slave_ready`  out  1  idle and able to accept a new transaction.
- `split_en`  out  1  split request during a long read wait.

## Operation
- **Reset values.** `slave_ready`=1; `tx_data`, `slave_valid` and `split_en` are 0; state is IDLE. RAM contents are not reset.
- **States.** IDLE, ADDR, BURST, WDATA, RWAIT, RFETCH, RDATA.
- **IDLE.**
  - Exactly one of `read_en` / `write_en` high with `master_valid`=1 takes address bit 0 and moves to ADDR.
  - Both enables high together: ignored, stay IDLE.
- **ADDR, BURST.** Shift one bit per cycle with `master_valid`=1; `master_valid`=0 holds (no shift). After ADDR_LEN address bits, go to BURST. After BURST_LEN burst bits, go to WDATA (write) or RWAIT (read).
- **Beats.** Beat count = burst value; a value of 0 is treated as 1.
- **WDATA.**
  - Shift DATA_LEN bits.
  - On the last bit, write `mem[addr]`, increment `addr` modulo 2^ADDR_LEN (4095→0), and decrement the beat count.
  - When beats remain, stay in WDATA; on the final beat, go to IDLE.
- **RWAIT.**
  - Count `slave_delay` cycles; 0 means skip directly to RFETCH.
  - `split_en`=1 throughout RWAIT when `slave_delay` ≥ SPLIT_THRESHOLD.
- **RFETCH.** One cycle for the synchronous RAM read; load the word into the tx shift register and deassert `split_en`.
- **RDATA.**
  - `slave_valid`=1 and `tx_data`=current bit.
  - Advance one bit only in cycles where `master_ready`=1.
  - After the last bit of a beat, increment `addr` (wrapping). Go to RWAIT if beats remain, else to IDLE with `slave_valid`=0.
- **Abort.** An active enable dropping in any non-IDLE state returns to IDLE next cycle.
  - Beats already written stay written.
  - A partial write word is discarded.
  - `slave_valid` and `split_en` clear.
- **Reset mid-transaction.** Immediate return to the reset values; no partial RAM write.
- `slave_ready`=1 only in IDLE.

## Timing
- Let T be the cycle address bit 0 is sampled, with continuous `master_valid`.
- Address bits occupy T..T+11; burst bits occupy T+12..T+23.
- **Write.** Data bits occupy T+24..T+31. The RAM write occurs on the clock edge ending T+31. `slave_ready`=1 at T+32 for a single-beat write.
- **Read, delay 0.** RFETCH at T+24. First valid bit at T+25. Last bit at T+32 with `master_ready` held high.
- Each read beat costs `slave_delay`+1+8 cycles minimum.
- `split_en` rises the cycle after the last burst bit, and falls in RFETCH.

## Structure
- Shared bus parameter package/header: `ADDR_LEN` / `DATA_LEN` / `BURST_LEN` defaults and the state encoding constants, also used by the master-side ports.
- One sub-module, `bram_sp`: a single-port synchronous RAM (write-first not required), parameterised by depth and width.
- Control FSM, shift registers and counters live in `bus_bram_slave`.

## Test plan
- **Single write then read.** Write addr 0x005, burst 1, data 0xA5; then read addr 0x005 with delay 0 → `tx_data` bits 1,0,1,0,0,1,0,1 over 8 cycles, `split_en` never high.
- **Burst write with wrap.** Burst write of 3 beats at addr 0xFFE with 0x11, 0x22, 0x33 → reading addr 0xFFE, 0xFFF, 0x000 returns 0x11, 0x22, 0x33.
- **Split on long delay.** Read with `slave_delay`=10 → `split_en` high for 10 cycles, low in RFETCH, then correct data.
- **Backpressure.** `master_ready` toggled 1,0,1,0 during a read → each bit is held while `master_ready`=0, and 8 accepted bits match the stored word.
- **Abort and reset.**
  - Drop `write_en` after 4 data bits → RAM unchanged, `slave_ready`=1 next cycle.
  - Assert `rst`=0 mid-read → outputs at their reset values immediately.
  - Both enables high in IDLE → no state change.
